// File: rtl/kernel_mem_pkg.sv
// Shared types and geometry for the kernel coefficient buffer.
// A line is 4 rows x 4 complex columns, and each half-bank holds 2 of those columns.
package kernel_mem_pkg;

  localparam int CW    = 32;
  localparam int AW    = 9;
  localparam int ROWS  = 4;
  localparam int HCOLS = 2;
  localparam int DW    = 2 * CW;
  localparam int LANES = ROWS * HCOLS;

  typedef struct packed {
    logic [CW-1:0] r;
    logic [CW-1:0] i;
  } complex_t;

endpackage

// File: rtl/kernel_mem_block_sdp_ram.sv
// Simple dual-port RAM with one write port and a registered, read-first read port.
// Only the read register is cleared by reset; the array contents survive reset.
module sdp_ram #(
  parameter int DW = 64,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [2**AW];
  logic [DW-1:0] rdata_r;

  // Array write; reset only blocks the write, it never clears stored words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read register samples the pre-write contents, which gives read-first behaviour
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= {DW{1'b0}};
    end else begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/kernel_mem_block.sv
// Kernel coefficient buffer: two half-banks of 8 lanes each.
// The loader writes one half-line per cycle, and the MAC array reads full 4x4 tiles.
module kernel_mem_block
  import kernel_mem_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   we,
  input  logic                   select,
  input  logic [AW-1:0]          write_address,
  input  logic [AW-1:0]          read_address,
  input  logic [LANES*DW-1:0]    in_data,
  output logic [2*LANES*DW-1:0]  out_data
);

  logic [1:0] bank_we_s;

  assign bank_we_s[0] = we & (select == 1'b0);
  assign bank_we_s[1] = we & (select == 1'b1);

  // Lane 2*i+j of bank b feeds output row i, column b*HCOLS+j
  for (genvar b = 0; b < 2; b++) begin : g_bank
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      localparam int ROW = l / HCOLS;
      localparam int COL = b * HCOLS + (l % HCOLS);
      localparam int OUT_WORD = ROW * 2 * HCOLS + COL;

      sdp_ram #(
        .DW(DW),
        .AW(AW)
      ) u_ram (
        .clk  (clk),
        .rst_n(reset_n),
        .we   (bank_we_s[b]),
        .waddr(write_address),
        .wdata(in_data[l*DW +: DW]),
        .raddr(read_address),
        .rdata(out_data[OUT_WORD*DW +: DW])
      );
    end
  end

endmodule

// File: tb/tb_kernel_mem_block.sv
// Randomized and directed bench for kernel_mem_block.
// A bank/row/column array model supplies every expected read result.
module tb_kernel_mem_block;
  import kernel_mem_pkg::*;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          we = 1'b0;
  logic          select = 1'b0;
  logic [8:0]    write_address = 9'd0;
  logic [8:0]    read_address = 9'd0;
  logic [511:0]  in_data = '0;
  logic [1023:0] out_data;

  int checks = 0;
  int failures = 0;

  // model[bank][addr][row][col within half]
  logic [63:0] model [2][512][4][2];

  kernel_mem_block dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .we           (we),
    .select       (select),
    .write_address(write_address),
    .read_address (read_address),
    .in_data      (in_data),
    .out_data     (out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    int first;
    checks++;
    if (got !== exp) begin
      failures++;
      first = 0;
      for (int k = 15; k >= 0; k--) begin
        if (got[k*64 +: 64] !== exp[k*64 +: 64]) first = k;
      end
      $display("FAIL %s word%0d got=%h exp=%h", tag, first,
               got[first*64 +: 64], exp[first*64 +: 64]);
    end
  endtask

  function automatic logic [1023:0] model_read(input logic [8:0] a);
    logic [1023:0] v;
    v = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        v[(i*4+j)*64 +: 64] = model[j/2][a][i][j%2];
    return v;
  endfunction

  function automatic logic [511:0] half_pat(input int a, input int base);
    logic [511:0] d;
    complex_t c;
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 2; j++) begin
        r = 32'(base + 16*a + 2*i + j);
        c.r = r;
        c.i = ~r;
        d[(i*2+j)*64 +: 64] = c;
      end
    return d;
  endfunction

  function automatic logic [511:0] fill(input logic [63:0] w);
    logic [511:0] d;
    for (int k = 0; k < 8; k++) d[k*64 +: 64] = w;
    return d;
  endfunction

  function automatic logic [511:0] rand_half();
    logic [511:0] d;
    for (int k = 0; k < 8; k++) d[k*64 +: 64] = {$urandom, $urandom};
    return d;
  endfunction

  // One clock: drive inputs, predict the read from pre-write contents, then check.
  task automatic step(input logic w, input logic s, input logic [8:0] wa,
                      input logic [8:0] ra, input logic [511:0] d,
                      input bit chk, input string tag);
    logic [1023:0] exp;
    we = w;
    select = s;
    write_address = wa;
    read_address = ra;
    in_data = d;
    exp = reset_n ? model_read(ra) : '0;
    if (w && reset_n)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 2; j++)
          model[s][wa][i][j] = d[(i*2+j)*64 +: 64];
    @(posedge clk);
    #1;
    if (chk) check_eq(tag, out_data, exp);
  endtask

  initial begin
    // Reset held with writes attempted: output stays zero
    we = 1'b1;
    in_data = fill(64'hDEAD_BEEF_0BAD_F00D);
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_hold", out_data, '0);
    we = 1'b0;
    reset_n = 1'b1;

    // Give every location a defined value
    for (int a = 0; a < 512; a++)
      for (int b = 0; b < 2; b++)
        step(1'b1, b[0], 9'(a), 9'd0, rand_half(), 1'b0, "preload");

    // Half-line writes, then streamed reads
    for (int a = 0; a < 16; a++) step(1'b1, 1'b0, 9'(a), 9'd0, half_pat(a, 0), 1'b0, "half_wr");
    for (int a = 0; a < 16; a++) step(1'b1, 1'b1, 9'(a), 9'd0, half_pat(a, 256), 1'b0, "half_wr");
    for (int a = 0; a < 16; a++) begin
      step(1'b0, 1'b0, 9'd0, 9'(a), '0, 1'b1, "half_rd");
      if (a == 3) check_eq("half_w12", 1024'(out_data[6*64 +: 64]), 1024'({32'h132, ~32'h132}));
    end

    // Bank isolation
    step(1'b1, 1'b0, 9'd5, 9'd0, fill(64'hAAAAAAAA_AAAAAAAA), 1'b0, "iso_wr");
    step(1'b1, 1'b1, 9'd5, 9'd0, fill(64'h55555555_55555555), 1'b0, "iso_wr");
    step(1'b0, 1'b0, 9'd0, 9'd5, '0, 1'b1, "iso_rd");
    check_eq("iso_col0", 1024'(out_data[12*64 +: 64]), 1024'(64'hAAAAAAAA_AAAAAAAA));
    check_eq("iso_col3", 1024'(out_data[15*64 +: 64]), 1024'(64'h55555555_55555555));

    // Read-during-write on the same bank and address returns old data
    step(1'b1, 1'b0, 9'd7, 9'd0, fill(64'd1), 1'b0, "rdw_init");
    step(1'b1, 1'b0, 9'd7, 9'd7, fill(64'd2), 1'b1, "rdw_same");
    check_eq("rdw_old", 1024'(out_data[63:0]), 1024'(64'd1));
    step(1'b0, 1'b0, 9'd0, 9'd7, '0, 1'b1, "rdw_next");
    check_eq("rdw_new", 1024'(out_data[63:0]), 1024'(64'd2));

    // Address corners
    step(1'b1, 1'b0, 9'd0, 9'd0, fill(64'h01234567_89ABCDEF), 1'b0, "wrap_wr");
    step(1'b1, 1'b0, 9'd511, 9'd0, fill(64'hFEDCBA98_76543210), 1'b0, "wrap_wr");
    step(1'b0, 1'b0, 9'd0, 9'd0, '0, 1'b1, "wrap_rd0");
    check_eq("wrap_a0", 1024'(out_data[63:0]), 1024'(64'h01234567_89ABCDEF));
    step(1'b0, 1'b0, 9'd0, 9'd511, '0, 1'b1, "wrap_rd511");
    check_eq("wrap_a511", 1024'(out_data[63:0]), 1024'(64'hFEDCBA98_76543210));

    // we=0 with busy data and toggling select
    for (int k = 0; k < 20; k++)
      step(1'b0, k[0], 9'($urandom_range(0, 15)), 9'($urandom_range(0, 15)),
           rand_half(), 1'b1, "we0");

    // Random traffic in a narrow window to force collisions
    for (int k = 0; k < 400; k++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           9'($urandom_range(0, 31)), 9'($urandom_range(0, 31)),
           rand_half(), 1'b1, "random");

    // Asynchronous clear mid-read, suppressed writes, then release
    step(1'b1, 1'b0, 9'd3, 9'd0, half_pat(3, 0), 1'b0, "rst_prep");
    step(1'b0, 1'b0, 9'd0, 9'd3, '0, 1'b1, "rst_pre");
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rst_async", out_data, '0);
    step(1'b1, 1'b0, 9'd3, 9'd3, fill(64'hFFFF_FFFF_FFFF_FFFF), 1'b1, "rst_wr0");
    step(1'b1, 1'b1, 9'd3, 9'd3, fill(64'hFFFF_FFFF_FFFF_FFFF), 1'b1, "rst_wr1");
    reset_n = 1'b1;
    step(1'b0, 1'b0, 9'd0, 9'd3, '0, 1'b1, "rst_release");
    check_eq("rst_keep", 1024'(out_data[63:0]), 1024'({32'h30, ~32'h30}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
